// File: rtl/masked_subbytes_seq_pkg.sv
// Shared constants, FSM encoding and share/byte slicing helper for the
// byte-serial masked SubBytes sequencer.
package masked_subbytes_seq_pkg;

    localparam int NB_BYTES = 16;
    localparam int STATE_W  = 8 * NB_BYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    // Bit offset of byte byteIdx of share shareIdx in a packed shared state.
    function automatic int byte_offset(input int shareIdx, input int byteIdx);
        return STATE_W * shareIdx + 8 * byteIdx;
    endfunction

endpackage

// File: rtl/shared_byte_shreg.sv
// SHARES-wide 16-byte shift register: each share shifts right by one byte
// independently, with a new byte per share entering at byte 15.
module shared_byte_shreg
    import masked_subbytes_seq_pkg::*;
#(
    parameter int SHARES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        load_i,
    input  logic                        shift_i,
    input  logic [STATE_W*SHARES-1:0]   data_i,
    input  logic [8*SHARES-1:0]         shiftIn_i,
    output logic [STATE_W*SHARES-1:0]   data_o
);

    logic [STATE_W*SHARES-1:0] data_q;
    logic [STATE_W*SHARES-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            for (int s = 0; s < SHARES; s++) begin
                for (int b = 0; b < NB_BYTES - 1; b++) begin
                    data_d[byte_offset(s, b) +: 8] = data_q[byte_offset(s, b + 1) +: 8];
                end
                data_d[byte_offset(s, NB_BYTES - 1) +: 8] = shiftIn_i[8*s +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/masked_subbytes_seq.sv
// Byte-serial SubBytes sequencer wrapped around a pipelined masked S-box.
// All data paths are share-wise; shares are never recombined here.
module masked_subbytes_seq
    import masked_subbytes_seq_pkg::*;
#(
    parameter int SHARES   = 2,
    parameter int SBOX_LAT = 5
) (
    input  logic                        ClkxCI,
    input  logic                        RstxBI,
    input  logic                        InValidxSI,
    output logic                        InReadyxSO,
    input  logic [STATE_W*SHARES-1:0]   _StatexDI,
    output logic [8*SHARES-1:0]         _SboxInxDO,
    output logic                        SboxEnxSO,
    input  logic [8*SHARES-1:0]         _SboxOutxDI,
    output logic [STATE_W*SHARES-1:0]   _StatexDO,
    output logic                        OutValidxSO,
    input  logic                        OutReadyxSI
);

    seq_state_e              state_q, state_d;
    logic [3:0]              feedCnt_q, feedCnt_d;
    logic [4:0]              collectCnt_q, collectCnt_d;
    logic [SBOX_LAT-1:0]     inflight_q, inflight_d;

    logic                    inLoad;
    logic                    inShift;
    logic                    resClear;
    logic                    capture;
    logic [STATE_W*SHARES-1:0] inState;
    logic [STATE_W*SHARES-1:0] resState;

    // Only bytes we issued ourselves are collected; stale S-box outputs after
    // an abort never see a set tail bit.
    assign capture = inflight_q[SBOX_LAT-1] && ((state_q == FEED) || (state_q == DRAIN));

    always_comb begin
        state_d      = state_q;
        feedCnt_d    = feedCnt_q;
        collectCnt_d = collectCnt_q;
        inLoad       = 1'b0;
        inShift      = 1'b0;
        resClear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (InValidxSI) begin
                    inLoad       = 1'b1;
                    feedCnt_d    = 4'd0;
                    collectCnt_d = 5'd0;
                    state_d      = FEED;
                end
            end
            FEED: begin
                inShift   = 1'b1;
                feedCnt_d = feedCnt_q + 4'd1;
                if (feedCnt_q == 4'd15) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (collectCnt_q == 5'(NB_BYTES)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (OutReadyxSI) begin
                    resClear = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            collectCnt_d = collectCnt_q + 5'd1;
        end
    end

    always_comb begin
        inflight_d    = inflight_q << 1;
        inflight_d[0] = (state_q == FEED);
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            state_q      <= IDLE;
            feedCnt_q    <= '0;
            collectCnt_q <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            feedCnt_q    <= feedCnt_d;
            collectCnt_q <= collectCnt_d;
            inflight_q   <= inflight_d;
        end
    end

    // Input shares drain out byte by byte; zeros fill behind them.
    shared_byte_shreg #(
        .SHARES (SHARES)
    ) u_in_shreg (
        .clk_i     (ClkxCI),
        .rst_ni    (RstxBI),
        .clear_i   (1'b0),
        .load_i    (inLoad),
        .shift_i   (inShift),
        .data_i    (_StatexDI),
        .shiftIn_i ('0),
        .data_o    (inState)
    );

    shared_byte_shreg #(
        .SHARES (SHARES)
    ) u_res_shreg (
        .clk_i     (ClkxCI),
        .rst_ni    (RstxBI),
        .clear_i   (resClear),
        .load_i    (1'b0),
        .shift_i   (capture),
        .data_i    ('0),
        .shiftIn_i (_SboxOutxDI),
        .data_o    (resState)
    );

    always_comb begin
        _SboxInxDO = '0;
        if (state_q == FEED) begin
            for (int s = 0; s < SHARES; s++) begin
                _SboxInxDO[8*s +: 8] = inState[byte_offset(s, 0) +: 8];
            end
        end
    end

    assign InReadyxSO  = (state_q == IDLE);
    assign SboxEnxSO   = (state_q == FEED);
    assign OutValidxSO = (state_q == HOLD);
    assign _StatexDO   = (state_q == HOLD) ? resState : '0;

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Directed bench for masked_subbytes_seq with a behavioural 2-share masked
// AES S-box of matching pipeline latency.
module tb_masked_subbytes_seq;

    localparam int SHARES   = 2;
    localparam int SBOX_LAT = 5;
    localparam int LAT_EXP  = 17 + SBOX_LAT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [255:0] stateIn;
    logic [15:0]  sboxIn;
    logic         sboxEn;
    logic [15:0]  sboxOut;
    logic [255:0] stateOut;
    logic         outValid;
    logic         outReady;

    int checks = 0;
    int errors = 0;

    logic [7:0]    sboxTab [256];
    logic [2047:0] tabBits;
    logic [15:0]   pipe [SBOX_LAT];
    logic [7:0]    modelMask;
    logic [7:0]    modelY;

    logic [255:0] got;
    logic [255:0] held;
    int           lat;

    masked_subbytes_seq #(
        .SHARES   (SHARES),
        .SBOX_LAT (SBOX_LAT)
    ) dut (
        .ClkxCI      (clk),
        .RstxBI      (rstN),
        .InValidxSI  (inValid),
        .InReadyxSO  (inReady),
        ._StatexDI   (stateIn),
        ._SboxInxDO  (sboxIn),
        .SboxEnxSO   (sboxEn),
        ._SboxOutxDI (sboxOut),
        ._StatexDO   (stateOut),
        .OutValidxSO (outValid),
        .OutReadyxSI (outReady)
    );

    // Masked S-box model: recombines only to look up the table, then
    // re-masks with a fresh random byte each cycle.
    always @(posedge clk) begin
        modelMask = 8'($urandom);
        modelY    = sboxTab[sboxIn[7:0] ^ sboxIn[15:8]];
        pipe[0]  <= {modelMask, modelY ^ modelMask};
        for (int k = 1; k < SBOX_LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end
    assign sboxOut = pipe[SBOX_LAT-1];

    function automatic logic [255:0] share2(input logic [127:0] x);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return {r, x ^ r};
    endfunction

    function automatic logic [127:0] unshare(input logic [255:0] s);
        return s[127:0] ^ s[255:128];
    endfunction

    function automatic logic [127:0] subBytesRef(input logic [127:0] x);
        logic [127:0] y;
        for (int b = 0; b < 16; b++) begin
            y[8*b +: 8] = sboxTab[x[8*b +: 8]];
        end
        return y;
    endfunction

    // Offers x (freshly shared) and waits for OutValid; lat = edges from accept.
    task automatic applyStimulus(input logic [127:0] x);
        stateIn = share2(x);
        inValid = 1'b1;
        @(posedge clk);
        lat = -1;
        got = '0;
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            inValid = 1'b0;
            stateIn = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (outValid) begin
                lat = e;
                got = stateOut;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic releaseResult();
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        rstN     = 1'b0;
        inValid  = 1'b1;
        outReady = 1'b0;
        stateIn  = share2(128'h0123456789abcdef0123456789abcdef);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN    = 1'b1;
        inValid = 1'b0;
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_inReady: got %b expected 1", inReady); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outValid: got %b expected 0", outValid); end
        checks++; if (sboxEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_sboxEn: got %b expected 0", sboxEn); end
        checks++; if (stateOut !== 256'h0) begin errors++; $display("[TB] FAIL reset_stateOut: got %h expected 0", stateOut); end
        checks++; if (sboxIn !== 16'h0) begin errors++; $display("[TB] FAIL reset_sboxIn: got %h expected 0", sboxIn); end
    endtask

    task automatic test_functional();
        logic [127:0] x;
        int enBad;
        int enCount;
        int inBad;
        x        = 128'h00112233445566778899aabbccddeeff;
        enBad    = 0;
        enCount  = 0;
        inBad    = 0;
        lat      = -1;
        got      = '0;
        stateIn  = share2(x);
        inValid  = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            inValid = 1'b0;
            stateIn = '0;
            if (sboxEn !== 1'(e < 16)) enBad++;
            if (sboxEn === 1'b1) enCount++;
            if (sboxEn !== 1'b1 && sboxIn !== 16'h0) inBad++;
            if (outValid) begin
                lat = e;
                got = stateOut;
                break;
            end
            @(posedge clk);
        end
        checks++; if (enBad != 0) begin errors++; $display("[TB] FAIL func_en_window: %0d cycles off, expected 0", enBad); end
        checks++; if (enCount != 16) begin errors++; $display("[TB] FAIL func_en_count: got %0d expected 16", enCount); end
        checks++; if (inBad != 0) begin errors++; $display("[TB] FAIL func_sboxIn_idle_zero: %0d nonzero cycles, expected 0", inBad); end
        checks++; if (lat != LAT_EXP) begin errors++; $display("[TB] FAIL func_latency: got %0d expected %0d", lat, LAT_EXP); end
        checks++; if (unshare(got) !== subBytesRef(x)) begin errors++; $display("[TB] FAIL func_data: got %h expected %h", unshare(got), subBytesRef(x)); end
        checks++; if (unshare(got) !== 128'h638293c31bfc33f5c4eeacea4bc12816) begin errors++; $display("[TB] FAIL func_known_vector: got %h expected 638293c31bfc33f5c4eeacea4bc12816", unshare(got)); end
        releaseResult();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL func_release_outValid: got %b expected 0", outValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL func_release_inReady: got %b expected 1", inReady); end
        checks++; if (stateOut !== 256'h0) begin errors++; $display("[TB] FAIL func_release_stateOut: got %h expected 0", stateOut); end
    endtask

    task automatic test_backpressure();
        logic [127:0] x;
        x        = 128'h3243f6a8885a308d313198a2e0370734;
        outReady = 1'b0;
        applyStimulus(x);
        checks++; if (lat != LAT_EXP) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, LAT_EXP); end
        checks++; if (unshare(got) !== subBytesRef(x)) begin errors++; $display("[TB] FAIL bp_data: got %h expected %h", unshare(got), subBytesRef(x)); end
        held    = got;
        inValid = 1'b1;
        stateIn = share2(128'hffffffffffffffffffffffffffffffff);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (stateOut !== held) begin errors++; $display("[TB] FAIL bp_stable: cycle %0d got %h expected %h", c, stateOut, held); end
            checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_inReady: cycle %0d got %b expected 0", c, inReady); end
            checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_outValid: cycle %0d got %b expected 1", c, outValid); end
        end
        inValid = 1'b0;
        releaseResult();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_outValid: got %b expected 0", outValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_inReady: got %b expected 1", inReady); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] x;
        logic [127:0] y;
        x        = 128'hffeeddccbbaa99887766554433221100;
        y        = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        outReady = 1'b1;
        applyStimulus(x);
        checks++; if (lat != LAT_EXP) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", lat, LAT_EXP); end
        checks++; if (unshare(got) !== subBytesRef(x)) begin errors++; $display("[TB] FAIL b2b_first_data: got %h expected %h", unshare(got), subBytesRef(x)); end
        inValid = 1'b1;
        stateIn = share2(y);
        @(posedge clk);
        @(negedge clk);
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_release_outValid: got %b expected 0", outValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_not_same_cycle: inReady got %b expected 1", inReady); end
        checks++; if (sboxEn !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_early_feed: sboxEn got %b expected 0", sboxEn); end
        applyStimulus(y);
        checks++; if (lat != LAT_EXP) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", lat, LAT_EXP); end
        checks++; if (unshare(got) !== subBytesRef(y)) begin errors++; $display("[TB] FAIL b2b_second_data: got %h expected %h", unshare(got), subBytesRef(y)); end
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_release: got %b expected 0", outValid); end
    endtask

    task automatic test_midop_reset();
        logic [127:0] x;
        logic [127:0] y;
        x       = 128'h00112233445566778899aabbccddeeff;
        y       = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        stateIn = share2(x);
        inValid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            inValid = 1'b0;
            if (c < 8) @(posedge clk);
        end
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL midrst_inReady: got %b expected 1", inReady); end
        checks++; if (sboxEn !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sboxEn: got %b expected 0", sboxEn); end
        applyStimulus(y);
        checks++; if (lat != LAT_EXP) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", lat, LAT_EXP); end
        checks++; if (unshare(got) !== subBytesRef(y)) begin errors++; $display("[TB] FAIL midrst_data: got %h expected %h", unshare(got), subBytesRef(y)); end
        releaseResult();
    endtask

    task automatic test_ignored_input();
        logic [127:0] x;
        int extra;
        x       = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        extra   = 0;
        lat     = -1;
        got     = '0;
        stateIn = share2(x);
        inValid = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            inValid = (e == 4);
            stateIn = (e == 4) ? share2(128'h00112233445566778899aabbccddeeff) : '0;
            if (outValid) begin
                lat = e;
                got = stateOut;
                break;
            end
            @(posedge clk);
        end
        inValid = 1'b0;
        checks++; if (lat != LAT_EXP) begin errors++; $display("[TB] FAIL ign_latency: got %0d expected %0d", lat, LAT_EXP); end
        checks++; if (unshare(got) !== subBytesRef(x)) begin errors++; $display("[TB] FAIL ign_data: got %h expected %h", unshare(got), subBytesRef(x)); end
        releaseResult();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sboxEn === 1'b1 || outValid === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL ign_single_txn: %0d active cycles after release, expected 0", extra); end
    endtask

    initial begin
        tabBits = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        for (int i = 0; i < 256; i++) begin
            sboxTab[i] = tabBits[2047 - 8*i -: 8];
        end
        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        stateIn  = '0;

        test_reset();
        test_functional();
        test_backpressure();
        test_back_to_back();
        test_midop_reset();
        test_ignored_input();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
